// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one 2-bit full-adder slice per cycle, LSB first.
// Subtract is a + ~b + 1; cbout reports carry (add) or borrow (subtract).
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             start,
  output logic [WIDTH-1:0] sum,
  output logic             cbout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned Slices = WIDTH / 2;
  localparam int unsigned CntW   = (Slices > 1) ? $clog2(Slices) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              mode_q, mode_d;
  logic              carry_q, carry_d;
  logic              cbout_q, cbout_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              accept;
  logic              last;
  logic [1:0]        slice_sum;
  logic              c_mid;
  logic              c_out;
  logic [WIDTH+1:0]  res_wide;

  // 2-bit ripple slice on the current low bits of the shifting operands
  always_comb begin
    slice_sum[0] = a_q[0] ^ b_q[0] ^ carry_q;
    c_mid        = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    slice_sum[1] = a_q[1] ^ b_q[1] ^ c_mid;
    c_out        = (a_q[1] & b_q[1]) | (c_mid & (a_q[1] ^ b_q[1]));
  end

  // New slice bits enter at the top so the result is aligned after the last slice
  assign res_wide = {slice_sum, res_q};
  assign accept   = start & ((state_q == StIdle) | (state_q == StDone));
  assign last     = (cnt_q == CntW'(Slices - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cbout_d = cbout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b ^ {WIDTH{mode}};
          mode_d  = mode;
          carry_d = mode;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      StRun: begin
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        res_d   = res_wide[WIDTH+1:2];
        carry_d = c_out;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          state_d = StDone;
          sum_d   = res_wide[WIDTH+1:2];
          cbout_d = c_out ^ mode_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cbout_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cbout_q <= cbout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum   = sum_q;
  assign cbout = cbout_q;
  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);

endmodule
